sign_multiplier: RTL

Sequential shift-and-add multiplier, the multiplicative counterpart of the library's iterative signed divider.
- Multiplies two INPUT_BIT_WIDTH-bit operands, signed or unsigned (selected per operation), into a 2×INPUT_BIT_WIDTH-bit product.
- Processes one multiplier bit per clock.
- Uses a Start/Ready/Done handshake so it drops into the same datapaths as the divider, e.g. paired with it in an arithmetic unit.

---
 rtl/sign_multiplier.sv | 120 ++++++++++++
 1 files changed

// File: rtl/sign_multiplier.sv
// Iterative shift-and-add multiplier, signed or unsigned per operation.
// Ports: Clk, nReset, Start/Sign/Multiplicand/Multiplier in; Product/Ready/Done out.
module sign_multiplier #(
  parameter int INPUT_BIT_WIDTH = 8
) (
  input  logic                           Clk,
  input  logic                           nReset,
  input  logic                           Start,
  input  logic                           Sign,
  input  logic [INPUT_BIT_WIDTH-1:0]     Multiplicand,
  input  logic [INPUT_BIT_WIDTH-1:0]     Multiplier,
  output logic [2*INPUT_BIT_WIDTH-1:0]   Product,
  output logic                           Ready,
  output logic                           Done
);

  localparam int W  = INPUT_BIT_WIDTH;
  localparam int PW = 2 * W;
  localparam int CW = $clog2(W + 1);

  localparam logic [CW-1:0] CNT_INIT = CW'(W);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } state_t;

  state_t          state_q;
  logic [PW-1:0]   mcand_q;
  logic [W-1:0]    mplier_q;
  logic [PW-1:0]   acc_q;
  logic [CW-1:0]   cnt_q;
  logic            neg_q;
  logic [PW-1:0]   product_q;
  logic            ready_q;
  logic            done_q;

  logic [W-1:0]    mag_a_d;
  logic [W-1:0]    mag_b_d;
  logic            neg_d;
  logic [PW-1:0]   acc_d;
  logic [PW-1:0]   res_d;
  logic            last_d;

  // Magnitudes are W-bit unsigned, so the most negative
  // operand maps to 2^(W-1) without overflow.
  always_comb begin
    mag_a_d = Multiplicand;
    mag_b_d = Multiplier;
    if (Sign && Multiplicand[W-1]) begin
      mag_a_d = -Multiplicand;
    end
    if (Sign && Multiplier[W-1]) begin
      mag_b_d = -Multiplier;
    end
    neg_d = Sign & (Multiplicand[W-1] ^ Multiplier[W-1]);
  end

  // Final step folds its own partial product in before
  // the result is written, so the sum is the true total.
  always_comb begin
    acc_d  = acc_q;
    if (mplier_q[0]) begin
      acc_d = acc_q + mcand_q;
    end
    res_d  = neg_q ? -acc_d : acc_d;
    last_d = (cnt_q == CNT_ONE);
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state_q   <= S_IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (Start) begin
            mcand_q  <= {{W{1'b0}}, mag_a_d};
            mplier_q <= mag_b_d;
            neg_q    <= neg_d;
            acc_q    <= '0;
            cnt_q    <= CNT_INIT;
            ready_q  <= 1'b0;
            state_q  <= S_BUSY;
          end
        end
        S_BUSY: begin
          acc_q    <= acc_d;
          mcand_q  <= {mcand_q[PW-2:0], 1'b0};
          mplier_q <= {1'b0, mplier_q[W-1:1]};
          cnt_q    <= cnt_q - CNT_ONE;
          if (last_d) begin
            product_q <= res_d;
            done_q    <= 1'b1;
            ready_q   <= 1'b1;
            state_q   <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign Product = product_q;
  assign Ready   = ready_q;
  assign Done    = done_q;

endmodule
